// File: rtl/countdown_display_if.sv
// Handshake bundle between the countdown display and its driver: clock enable,
// the two remaining-time values, and the display/status outputs.
interface countdown_display_if;
   logic       ce;
   logic [6:0] timeLeftNS;
   logic [6:0] timeLeftEW;
   logic [3:0] an;
   logic [6:0] seg;
   logic       busy;
   logic       upd;

   modport master (
      output ce, timeLeftNS, timeLeftEW,
      input  an, seg, busy, upd
   );

   modport slave (
      input  ce, timeLeftNS, timeLeftEW,
      output an, seg, busy, upd
   );
endinterface

// File: rtl/countdown_display.sv
// Converts the NS/EW remaining-time values to BCD with a sequential double-dabble
// engine and scans them onto a 4-digit common-anode 7-segment display.
module countdown_display #(
   parameter int SCAN_DIV = 4
) (
   input logic               clk,
   input logic               rst,
   countdown_display_if.slave bus
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, CONV_NS, CONV_EW, UPDATE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_iter;
   logic [2:0]  w_iter_nxt;
   logic        r_upd;
   logic        w_load_disp;

   logic [6:0]  r_src;
   logic [6:0]  w_src_nxt;
   logic [7:0]  r_bcd;
   logic [7:0]  w_bcd_nxt;
   logic [6:0]  r_cap_ew;
   logic [6:0]  w_cap_ew_nxt;
   logic [7:0]  r_ns_bcd;
   logic [7:0]  w_ns_bcd_nxt;
   logic [7:0]  w_dd;

   // {NS tens, NS ones, EW tens, EW ones}, indexed by the digit index
   logic [15:0] r_disp;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]  r_idx;
   logic [3:0]  r_an;
   logic [6:0]  r_seg;
   logic [3:0]  w_digit;
   logic [6:0]  w_seg;

   function automatic logic [6:0] clamp99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   function automatic logic [7:0] dabble(input logic [7:0] bcd, input logic msb);
      logic [7:0] adj;
      adj = bcd;
      if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
      if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
      return {adj[6:0], msb};
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign w_dd = dabble(r_bcd, r_src[6]);

   always_comb begin
      w_state_nxt  = r_state;
      w_iter_nxt   = r_iter;
      w_src_nxt    = r_src;
      w_bcd_nxt    = r_bcd;
      w_cap_ew_nxt = r_cap_ew;
      w_ns_bcd_nxt = r_ns_bcd;
      w_load_disp  = 1'b0;
      case (r_state)
         IDLE: begin
            w_src_nxt    = clamp99(bus.timeLeftNS);
            w_cap_ew_nxt = clamp99(bus.timeLeftEW);
            w_bcd_nxt    = 8'd0;
            w_iter_nxt   = 3'd0;
            w_state_nxt  = CONV_NS;
         end
         CONV_NS: begin
            w_bcd_nxt  = w_dd;
            w_src_nxt  = {r_src[5:0], 1'b0};
            w_iter_nxt = r_iter + 3'd1;
            if (r_iter == 3'd6) begin
               w_ns_bcd_nxt = w_dd;
               w_src_nxt    = r_cap_ew;
               w_bcd_nxt    = 8'd0;
               w_iter_nxt   = 3'd0;
               w_state_nxt  = CONV_EW;
            end
         end
         CONV_EW: begin
            w_bcd_nxt  = w_dd;
            w_src_nxt  = {r_src[5:0], 1'b0};
            w_iter_nxt = r_iter + 3'd1;
            if (r_iter == 3'd6) begin
               w_iter_nxt  = 3'd0;
               w_state_nxt = UPDATE;
            end
         end
         UPDATE: begin
            w_load_disp = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_digit = r_disp[{r_idx, 2'b00} +: 4];
      w_seg   = seg_decode(w_digit);
      // tens positions sit on odd indices; blank them when zero
      if (r_idx[0] && (w_digit == 4'd0)) w_seg = 7'b1111111;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_iter  <= 3'd0;
         r_upd   <= 1'b0;
         r_disp  <= 16'd0;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_an    <= 4'b1111;
         r_seg   <= 7'b1111111;
      end else if (bus.ce) begin
         r_state <= w_state_nxt;
         r_iter  <= w_iter_nxt;
         r_upd   <= w_load_disp;
         if (w_load_disp) r_disp <= {r_ns_bcd, r_bcd};
         if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= w_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.ce) begin
         r_src    <= w_src_nxt;
         r_bcd    <= w_bcd_nxt;
         r_cap_ew <= w_cap_ew_nxt;
         r_ns_bcd <= w_ns_bcd_nxt;
      end
   end

   assign bus.an   = r_an;
   assign bus.seg  = r_seg;
   assign bus.busy = (r_state != IDLE);
   assign bus.upd  = r_upd;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: directed and random stimulus compared each cycle
// against a reference built from edge counts and decimal arithmetic.
module tb_countdown_display;

   localparam int SCAN_DIV = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   countdown_display_if bus ();

   countdown_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

   // Reference state: enabled edges since reset, captured values, shown digits
   int         m_n;
   int         m_cap_ns;
   int         m_cap_ew;
   int         m_disp [4];
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic       m_upd;
   logic       m_busy;

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle_n=%0d observed=%b expected=%b", tag, m_n, obs, exp);
      end
   endtask

   task automatic step();
      int idx;
      int ph;
      if (!rst) begin
         m_n    = 0;
         for (int i = 0; i < 4; i++) m_disp[i] = 0;
         m_an   = 4'b1111;
         m_seg  = 7'b1111111;
         m_upd  = 1'b0;
         m_busy = 1'b0;
      end else if (bus.ce) begin
         idx   = (m_n / SCAN_DIV) % 4;
         m_an  = ~(4'b0001 << idx);
         m_seg = ((idx % 2 == 1) && (m_disp[idx] == 0)) ? 7'b1111111 : SEG_TAB[m_disp[idx]];
         ph    = m_n % 16;
         m_upd = 1'b0;
         if (ph == 0) begin
            m_cap_ns = (int'(bus.timeLeftNS) > 99) ? 99 : int'(bus.timeLeftNS);
            m_cap_ew = (int'(bus.timeLeftEW) > 99) ? 99 : int'(bus.timeLeftEW);
         end
         if (ph == 15) begin
            m_disp[0] = m_cap_ew % 10;
            m_disp[1] = m_cap_ew / 10;
            m_disp[2] = m_cap_ns % 10;
            m_disp[3] = m_cap_ns / 10;
            m_upd = 1'b1;
         end
         m_n++;
         m_busy = ((m_n % 16) != 0);
      end
      @(posedge clk);
      #1;
      check("an",   {3'b000, bus.an}, {3'b000, m_an});
      check("seg",  bus.seg,          m_seg);
      check("busy", {6'd0, bus.busy}, {6'd0, m_busy});
      check("upd",  {6'd0, bus.upd},  {6'd0, m_upd});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic align();
      for (int i = 0; i < 16 && (m_n % 16) != 0; i++) step();
   endtask

   initial begin
      rst = 1'b0;
      bus.ce = 1'b1;
      bus.timeLeftNS = 7'd0;
      bus.timeLeftEW = 7'd0;
      m_n = 0;
      m_cap_ns = 0;
      m_cap_ew = 0;

      run(3);

      rst = 1'b1;
      bus.timeLeftNS = 7'd25;
      bus.timeLeftEW = 7'd7;
      run(40);

      align();
      bus.timeLeftNS = 7'd120;
      bus.timeLeftEW = 7'd100;
      run(48);

      align();
      bus.timeLeftNS = 7'd99;
      bus.timeLeftEW = 7'd0;
      run(48);

      align();
      bus.timeLeftNS = 7'd57;
      bus.timeLeftEW = 7'd3;
      run(4);
      bus.ce = 1'b0;
      bus.timeLeftNS = 7'd11;
      run(5);
      bus.ce = 1'b1;
      run(40);

      align();
      bus.timeLeftNS = 7'd42;
      bus.timeLeftEW = 7'd18;
      run(9);
      rst = 1'b0;
      run(1);
      rst = 1'b1;
      run(40);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) bus.timeLeftNS = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) bus.timeLeftEW = 7'($urandom_range(0, 127));
         bus.ce = ($urandom_range(0, 9) != 0);
         rst    = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
